// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - binary32 post-adder normalize, round-to-nearest-even and pack stage
module fp_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_unf
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [8:0]  exp_q, exp_d;
    logic [24:0] mant_q, mant_d;
    logic        guard_q, guard_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [24:0] rnd_sum;
    logic [24:0] rnd_mant;
    logic [8:0]  rnd_exp;
    logic [8:0]  exp_inc;

    assign exp_inc = exp_q + 9'd1;

    // Sticky is always zero here, so a tie is exactly guard=1; round up only on an odd LSB.
    always_comb begin
        rnd_sum  = mant_q + {24'b0, guard_q & mant_q[0]};
        rnd_mant = rnd_sum;
        rnd_exp  = exp_q;
        if (rnd_sum[24]) begin
            rnd_mant = rnd_sum >> 1;
            rnd_exp  = exp_inc;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = {1'b0, in_exp};
                    mant_d   = in_mant;
                    guard_d  = 1'b0;
                    result_d = 32'b0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mant_q == 25'b0) begin
                    result_d = {sign_q, 31'b0};
                    zero_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (mant_q[24]) begin
                    guard_d = mant_q[0];
                    mant_d  = mant_q >> 1;
                    exp_d   = exp_inc;
                    if (exp_inc == 9'd255) begin
                        result_d = {sign_q, 8'hFF, 23'b0};
                        ovf_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_ROUND;
                    end
                end else if (mant_q[23]) begin
                    state_d = S_ROUND;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (mant_q[23]) begin
                    state_d = S_ROUND;
                end else if (exp_q == 9'd1) begin
                    result_d = {sign_q, 8'h00, mant_q[22:0]};
                    unf_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    // Look ahead at bit 22 so the final shift hands straight to ROUND.
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 9'd1;
                    if (mant_q[22]) begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                mant_d = rnd_mant;
                exp_d  = rnd_exp;
                if (rnd_exp == 9'd255) begin
                    result_d = {sign_q, 8'hFF, 23'b0};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, rnd_exp[7:0], rnd_mant[22:0]};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= 9'b0;
            mant_q   <= 25'b0;
            guard_q  <= 1'b0;
            result_q <= 32'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;
endmodule

// File: doc/fp_normalizer.md
# fp_normalizer

Post-adder normalize/round/pack stage for the single-precision floating-point add/sub datapath. It consumes the 25-bit unsigned mantissa magnitude produced by the mantissa adder/subtractor, together with the result sign and the pre-normalization biased exponent. It shifts the mantissa one bit per cycle until normalized, rounds to nearest-even, and emits a packed IEEE-754 word over a valid/ready handshake.

## Interface
- Parameters: none; fixed to binary32 (8-bit exponent, 23-bit fraction, 25-bit adder result).
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  input payload valid
- in_ready  output  1  block can accept; high exactly in IDLE
- in_sign  input  1  result sign
- in_exp  input  8  biased exponent of the larger operand, legal range 1..254
- in_mant  input  25  unsigned magnitude; bit 24 = adder carry, bit 23 = hidden-bit position
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  downstream accepts
- out_result  output  32  {sign, exp[7:0], frac[22:0]}
- out_zero  output  1  result is ±0
- out_ovf  output  1  overflow; result is ±inf
- out_unf  output  1  result is denormal (exponent field 0, nonzero fraction)

## Operation
- Reset: state IDLE; out_valid, out_result, out_zero, out_ovf and out_unf all 0; internal registers cleared. Inputs are ignored while rst_n is low. Reset mid-operation abandons the in-flight item with no output.
- IDLE: in_ready=1. On in_valid&in_ready, latch sign, exp, mant, and clear guard → CHECK.
- CHECK (1 cycle):
  - mant==0 → result {sign,31'b0}, zero=1 → DONE.
  - mant[24]=1 → guard=mant[0], mant=mant>>1, exp=exp+1. If the new exp==255 → result {sign,8'hFF,23'b0}, ovf=1 → DONE. Otherwise → ROUND.
  - mant[23]=1 → ROUND.
  - Otherwise → SHIFT.
- SHIFT (1 cycle per bit):
  - mant[23]=1 → ROUND.
  - Else if exp==1 → denormal: pack {sign,8'h00,mant[22:0]}, unf=1 → DONE. No rounding is needed because guard=0 on this path.
  - Else mant=mant<<1, exp=exp-1; stay in SHIFT.
- ROUND (1 cycle):
  - Increment iff guard&mant[0] (ties-to-even; sticky is always 0).
  - If the increment carries to bit 24 → mant>>1, exp+1. If exp==255 → ±inf, ovf=1.
  - Pack {sign,exp,mant[22:0]} → DONE.
- DONE: out_valid=1 with result and flags stable. On out_ready → IDLE, and out_valid drops the next cycle. Flags are mutually exclusive.
- Exponent arithmetic is 9 bits internally; only 8 bits are packed. An in_exp of 0 or 255 is illegal and produces undefined output.

## Timing
- Handshake accepted in cycle T. CHECK occupies T+1.
- Zero / overflow-at-CHECK: out_valid in T+2.
- Normalized or carry input: ROUND in T+2, out_valid in T+3.
- k left shifts: out_valid in T+3+k. Worst case k=23 gives T+26.
- Denormal exit: out_valid one cycle after the SHIFT cycle that sees exp==1.
- Throughput: one item in flight. in_ready=0 from T+1 until the cycle after the out handshake.
- out_ready=0 stalls DONE indefinitely with outputs held constant. out_ready is ignored when out_valid=0.
- in_valid with in_ready=0 is ignored; the upstream holds its payload.

## Test plan
- Carry path: sign=0, exp=127, mant=0x1000000 → out_result=0x40000000, all flags 0, out_valid at T+3.
- Long shift: exp=127, mant=0x0000001 → 0x34000000, out_valid at T+26. Hold out_ready=0 for 5 cycles; output must stay stable and in_ready must stay 0.
- Zero: sign=1, mant=0 → 0x80000000, out_zero=1, out_valid at T+2.
- Rounding:
  - exp=127, mant=0x1000003 → 0x40000002 (tie, odd LSB, increment).
  - mant=0x1000001 → 0x40000000 (tie, even LSB, no increment).
- Overflow / denormal:
  - exp=254, mant=0x1FFFFFF → 0x7F800000, out_ovf=1.
  - exp=3, mant=0x0000100 → 0x00000400, out_unf=1, out_valid at T+5.
- Reset mid-SHIFT: drop rst_n during the long-shift case → no out_valid, outputs 0, in_ready=1. A new item after release completes normally.
